ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte at a time to the keyboard, for example 0xED for set-LEDs or 0xFF for reset. It drives the shared PS/2 clock and data lines through open-drain enables. It sits beside the keyboard receiver and shares the same psClk/psData pins; the receiver must ignore line activity while `busy` is high.

## Interface
- CLK_HZ, 50_000_000, system clock frequency (informational only).
- INHIBIT_CYCLES, 6000, number of Clk cycles the host holds psClk low before the start bit (120 µs at 50 MHz).
- TIMEOUT_CYCLES, 1_000_000, limit on the whole device-clocked phase (20 ms at 50 MHz).
- Clk  in  1  system clock; all logic runs on posedge Clk.
- reset  in  1  asynchronous, active-high reset.
- tx_valid  in  1  command byte is valid.
- tx_data  in  8  command byte.
- tx_ready  out  1  block can accept a byte.
- psClk_in  in  1  raw PS/2 clock pin (asynchronous).
- psData_in  in  1  raw PS/2 data pin (asynchronous).
- psClk_oe  out  1  1 = pull psClk low; 0 = release.
- psData_oe  out  1  1 = pull psData low; 0 = release.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse: byte sent and device ACK seen.
- err  out  1  one-cycle pulse: timeout or missing ACK.

## Operation
- Reset values: psClk_oe=0, psData_oe=0, tx_ready=1, busy=0, done=0, err=0, state IDLE.
- Handshake: a byte is accepted when tx_valid && tx_ready in IDLE.
  - tx_data is latched into the shift register.
  - Parity is latched as odd parity: p = ~^tx_data.
  - tx_ready drops to 0 the next cycle.
- Pin inputs pass through 2-FF synchronizers.
  - fall = one-cycle pulse when the synchronized clock goes 1→0.
  - psClk_in is never used as a clock.
- State machine:
  - IDLE: tx_ready=1, busy=0. On accept → INHIBIT.
  - INHIBIT: psClk_oe=1; count INHIBIT_CYCLES. At the last count, psData_oe=1 (start bit = 0) → RELEASE.
  - RELEASE: psClk_oe=0; psData_oe stays 1. Clear bit counter and timeout counter → DATA.
  - DATA: on each fall, drive the next bit with psData_oe = ~bit.
    - Falls 1–8 send bits 0–7, LSB first.
    - Fall 9 sends parity.
    - Fall 10 sets psData_oe=0 (stop bit = 1) → ACK.
  - ACK: on fall 11, sample the synchronized data. 0 → WAIT_IDLE; 1 → err pulse, then → IDLE.
  - WAIT_IDLE: wait until both synchronized clock and data are 1, then pulse done → IDLE.
- Timeout: counted in DATA, ACK and WAIT_IDLE. When the counter reaches TIMEOUT_CYCLES: err pulse, both oe=0, → IDLE.
- busy=1 in every state except IDLE.
- tx_valid is ignored while tx_ready=0. No queueing: one byte is in flight at a time.
- Simultaneous timeout and fall in the same cycle: timeout wins.

## Timing
- Accept to psClk_oe=1: 1 cycle.
- psClk_oe stays asserted for exactly INHIBIT_CYCLES cycles.
- psData_oe rises in the same cycle psClk_oe falls.
- Bit update: psData_oe changes 1 cycle after the fall pulse, which is 3 cycles after the raw pin edge (2 sync + 1 register).
- done and err are each high for exactly 1 cycle. They are never both high.
- Return to IDLE: tx_ready=1 the cycle after the done or err pulse.
- Reset mid-transfer: both oe outputs go to 0 immediately (asynchronous). All counters clear. Nothing is pulsed.

## Structure
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, RELEASE, DATA, ACK, WAIT_IDLE.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4.
  - Response constant: PS2_RSP_ACK=8'hFA.
- Sub-module ps2_line_sync: one instance per pin. Provides the 2-FF synchronizer, the synchronized level, and the fall pulse.
- Counters:
  - inhibit counter, 16 bits.
  - timeout counter, 20 bits.
  - bit counter, 4 bits, range 0–11.

## Test plan
Sim parameters: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000. The device model clocks at a 40-Clk period.
- Send 0xED with the device ACKing → data bits seen at the device are 1,0,1,1,0,1,1,1, then parity 1, then stop 1. done pulses once; err=0; tx_ready returns to 1.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Both transfers pulse done.
- Device releases data (no ACK) at fall 11 → err pulses once, done=0, both oe=0, back in IDLE.
- Device never clocks after the start bit → err pulses 2000 cycles after RELEASE; psData_oe=0.
- Assert reset at bit 4 of a 0xFF transfer → oe outputs go to 0 at once. After reset release, tx_ready=1 and busy=0. The next send of 0xF4 completes with done.
- Hold tx_valid high with tx_data changing during a transfer → only the first byte is sent; the second byte is accepted only after tx_ready returns to 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding and command codes for the PS/2 host transmitter
package ps2_pkg;

    // Transmitter states
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] DATA      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer for one PS/2 pin with falling-edge pulse
module ps2_line_sync (
    input  logic Clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter driving open-drain enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = CLK_HZ / 1_000_000 * 120,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       psClk_in,
    input  logic       psData_in,
    output logic       psClk_oe,
    output logic       psData_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [15:0] INH_LAST = 16'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [15:0] r_inh_cnt;
    logic [19:0] r_to_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_data_oe;

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall_unused;
    logic w_timeout;

    ps2_line_sync u_clk_sync (
        .Clk     (Clk),
        .reset   (reset),
        .i_pin   (psClk_in),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .Clk     (Clk),
        .reset   (reset),
        .i_pin   (psData_in),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall_unused)
    );

    assign w_timeout = ((r_state == DATA) || (r_state == ACK) || (r_state == WAIT_IDLE))
                       && (r_to_cnt == TO_LAST);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_parity  <= odd_parity(tx_data);
                        r_inh_cnt <= '0;
                        r_state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= RELEASE;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_state   <= DATA;
                end
                DATA: begin
                    r_to_cnt <= r_to_cnt + 20'd1;
                    // Timeout takes priority over a coincident clock fall.
                    if (w_timeout) begin
                        r_data_oe <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_clk_fall) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < 4'd8) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd8) begin
                            r_data_oe <= ~r_parity;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= ACK;
                        end
                    end
                end
                ACK: begin
                    r_to_cnt <= r_to_cnt + 20'd1;
                    if (w_timeout) begin
                        r_data_oe <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_clk_fall) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_state   <= w_data_lvl ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    r_to_cnt <= r_to_cnt + 20'd1;
                    if (w_timeout || (w_clk_lvl && w_data_lvl)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pulses are decoded from the exiting state so tx_ready rises the cycle after.
    assign err       = w_timeout || ((r_state == ACK) && w_clk_fall && w_data_lvl);
    assign done      = (r_state == WAIT_IDLE) && !w_timeout && w_clk_lvl && w_data_lvl;
    assign tx_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign psClk_oe  = (r_state == INHIBIT);
    assign psData_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with an open-drain device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       par;
    } vec_t;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, psClk_oe, psData_oe, busy, done, err;
    logic       psClk_in, psData_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       prev_pulse = 1'b0;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];

    assign psClk_in  = ~(psClk_oe | dev_clk_low);
    assign psData_in = ~(psData_oe | dev_data_low);

    always #5 Clk = ~Clk;

    ps2_host_tx #(
        .CLK_HZ         (50_000_000),
        .INHIBIT_CYCLES (10),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .psClk_in  (psClk_in),
        .psData_in (psData_in),
        .psClk_oe  (psClk_oe),
        .psData_oe (psData_oe),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    always @(negedge Clk) begin
        if (prev_pulse) chk("ready_after_pulse", {31'b0, tx_ready}, 32'd1);
        prev_pulse = done | err;
        if (done) n_done++;
        if (err) n_err++;
        if (done || err) chk("done_err_exclusive", {31'b0, done & err}, 32'd0);
    end

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!tx_ready && k < 200) begin
            @(negedge Clk);
            k++;
        end
        chk(name, {31'b0, tx_ready}, 32'd1);
    endtask

    // Presents a byte (unless already on the bus) and checks inhibit/start timing.
    task automatic start_tx(input logic [7:0] d, input bit hold, input bit present);
        int k;
        if (present) begin
            @(negedge Clk);
            tx_valid = 1'b1;
            tx_data  = d;
        end
        @(negedge Clk);
        if (!hold) tx_valid = 1'b0;
        chk("accept_ready_low", {31'b0, tx_ready}, 32'd0);
        chk("accept_clk_oe", {31'b0, psClk_oe}, 32'd1);
        k = 0;
        while (psClk_oe && k < 100) begin
            @(negedge Clk);
            k++;
        end
        chk("inhibit_len", k, 32'd10);
        chk("start_bit", {31'b0, psData_oe}, 32'd1);
    endtask

    // Device side: 40-Clk clock period, samples the line at the end of each low phase.
    task automatic run_device(input bit ack, input int n_falls,
                              output logic [9:0] bits, output int lat);
        bits = '0;
        lat  = -1;
        for (int n = 1; n <= n_falls; n++) begin
            if (n == 11) dev_data_low = ack;
            repeat (20) @(negedge Clk);
            dev_clk_low = 1'b1;
            for (int j = 1; j <= 20; j++) begin
                @(negedge Clk);
                if (n == 1 && lat < 0 && psData_oe == 1'b0) lat = j;
            end
            if (n <= 10) bits[n-1] = psData_in;
            dev_clk_low = 1'b0;
        end
        if (n_falls == 11) begin
            dev_data_low = 1'b0;
            wait_ready("return_ready");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        logic [9:0] got;
        logic [9:0] expf;
        int         lat;
        int         k;

        vecs[0] = '{data: PS2_CMD_SET_LED, ack: 1'b1, par: 1'b1};
        vecs[1] = '{data: 8'h00,           ack: 1'b1, par: 1'b1};
        vecs[2] = '{data: 8'h01,           ack: 1'b1, par: 1'b0};
        vecs[3] = '{data: PS2_CMD_ENABLE,  ack: 1'b1, par: 1'b0};
        vecs[4] = '{data: 8'h3C,           ack: 1'b0, par: 1'b1};
        vecs[5] = '{data: 8'h80,           ack: 1'b1, par: 1'b0};

        repeat (2) @(negedge Clk);
        chk("rst_ready", {31'b0, tx_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_oe", {30'b0, psClk_oe, psData_oe}, 32'd0);
        reset = 1'b0;
        @(negedge Clk);
        chk("idle_pulses", {30'b0, done, err}, 32'd0);
        chk("idle_ready", {31'b0, tx_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            n_done = 0;
            n_err  = 0;
            exp_q.push_back({1'b1, vecs[i].par, vecs[i].data});
            start_tx(vecs[i].data, 1'b0, 1'b1);
            run_device(vecs[i].ack, 11, got, lat);
            expf = exp_q.pop_front();
            chk("frame", {22'b0, got}, {22'b0, expf});
            if (vecs[i].data[0]) chk("bit_latency", lat, 32'd3);
            chk("done_cnt", n_done, {31'b0, vecs[i].ack});
            chk("err_cnt", n_err, {31'b0, ~vecs[i].ack});
            chk("oe_released", {30'b0, psClk_oe, psData_oe}, 32'd0);
            chk("busy_clear", {31'b0, busy}, 32'd0);
        end

        // Device never clocks: timeout measured from the RELEASE cycle.
        n_done = 0;
        n_err  = 0;
        start_tx(PS2_CMD_RESET, 1'b0, 1'b1);
        k = 0;
        while (!err && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        chk("timeout_cycles", k, 32'd2000);
        @(negedge Clk);
        chk("timeout_data_oe", {31'b0, psData_oe}, 32'd0);
        chk("timeout_ready", {31'b0, tx_ready}, 32'd1);
        chk("timeout_err_cnt", n_err, 32'd1);
        chk("timeout_done_cnt", n_done, 32'd0);

        // Reset in the middle of a 0xFF transfer, then a clean 0xF4.
        n_done = 0;
        n_err  = 0;
        exp_q.push_back({1'b1, 1'b1, PS2_CMD_RESET});
        start_tx(PS2_CMD_RESET, 1'b0, 1'b1);
        run_device(1'b1, 5, got, lat);
        chk("busy_before_reset", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_async_oe", {30'b0, psClk_oe, psData_oe}, 32'd0);
        chk("reset_async_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("after_reset_ready", {31'b0, tx_ready}, 32'd1);
        chk("after_reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_no_pulse", n_done + n_err, 32'd0);
        exp_q.push_back({1'b1, 1'b0, PS2_CMD_ENABLE});
        start_tx(PS2_CMD_ENABLE, 1'b0, 1'b1);
        run_device(1'b1, 11, got, lat);
        expf = exp_q.pop_front();
        chk("post_reset_frame", {22'b0, got}, {22'b0, expf});
        chk("post_reset_done", n_done, 32'd1);

        // tx_valid held with tx_data changing: only the first byte goes out.
        n_done = 0;
        n_err  = 0;
        exp_q.push_back({1'b1, 1'b1, PS2_CMD_SET_LED});
        start_tx(PS2_CMD_SET_LED, 1'b1, 1'b1);
        fork
            run_device(1'b1, 11, got, lat);
            begin
                int m;
                m = 0;
                while (m < 2000) begin
                    @(negedge Clk);
                    m++;
                    if (tx_ready) begin
                        tx_data = 8'h81;
                        break;
                    end
                    tx_data = 8'($urandom);
                end
            end
        join
        expf = exp_q.pop_front();
        chk("hold_first_frame", {22'b0, got}, {22'b0, expf});
        chk("hold_first_done", n_done, 32'd1);
        exp_q.push_back({1'b1, 1'b1, 8'h81});
        start_tx(8'h81, 1'b0, 1'b0);
        run_device(1'b1, 11, got, lat);
        expf = exp_q.pop_front();
        chk("hold_second_frame", {22'b0, got}, {22'b0, expf});
        chk("hold_second_done", n_done, 32'd2);
        chk("hold_err_cnt", n_err, 32'd0);

        repeat (5) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
